adxl362_fifo_writer: RTL

- Write-side controller that sits directly upstream of the ADXL362 512x16 FIFO model.
- Takes one accelerometer/temperature sample set per `sample_valid` strobe, formats it into tagged 16-bit FIFO words and issues them one per cycle on the FIFO `write`/`data_write` inputs.
- Implements the ADXL362 FIFO modes (disabled, oldest-saved, stream, triggered), tracks the FIFO entry count, and drives the FIFO `read`, `flush` and watermark/overrun status.

---
 rtl/adxl362_fifo_writer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/adxl362_fifo_writer.sv
// Write-side controller for the ADXL362 512x16 FIFO: formats tagged sample sets,
// applies the oldest-saved / stream / triggered policies and tracks FIFO occupancy.
module adxl362_fifo_writer #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 512,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_valid,
  input  logic [11:0]          x_data,
  input  logic [11:0]          y_data,
  input  logic [11:0]          z_data,
  input  logic [11:0]          temp_data,
  input  logic [1:0]           fifo_mode,
  input  logic                 fifo_temp,
  input  logic [9:0]           fifo_samples,
  input  logic                 trigger,
  input  logic                 ext_read,
  input  logic                 clear_status,
  output logic                 fifo_write,
  output logic [WIDTH-1:0]     fifo_data_write,
  output logic                 fifo_read,
  output logic                 fifo_flush,
  output logic [CNT_WIDTH-1:0] entries,
  output logic                 watermark,
  output logic                 overrun,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, WRITE, DISCARD} state_t;

  localparam logic [1:0]           MODE_OFF    = 2'b00;
  localparam logic [1:0]           MODE_OLDEST = 2'b01;
  localparam logic [1:0]           MODE_TRIG   = 2'b11;
  localparam logic [CNT_WIDTH-1:0] FULL        = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE         = CNT_WIDTH'(1);

  state_t               state_reg, state_next;
  logic [1:0]           idx_reg, idx_next;
  logic                 write_reg, write_next;
  logic [WIDTH-1:0]     data_reg, data_next;
  logic                 flush_reg, flush_next;
  logic [CNT_WIDTH-1:0] entries_reg, entries_next;
  logic                 overrun_reg, overrun_next;
  logic                 trig_reg, trig_next;
  logic [CNT_WIDTH-1:0] post_reg, post_next;
  logic                 stream_set_reg, stream_set_next;
  logic                 temp_en_reg, temp_en_next;
  logic [1:0]           prev_mode_reg;

  logic [11:0]          sample_reg [4];
  logic [15:0]          word [4];

  logic                 capture, emit, busy_c, discard, read_c, pop, ext_pop;
  logic                 last_word, need_discard, mode_off_enter;
  logic [CNT_WIDTH-1:0] base_next, room, set_size, samples_ext;

  // Channel tag equals the slot index: X=00, Y=01, Z=10, T=11.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
      assign word[gi] = {2'(gi), {2{sample_reg[gi][11]}}, sample_reg[gi]};
    end
  endgenerate

  assign samples_ext    = CNT_WIDTH'(fifo_samples);
  assign busy_c         = (state_reg != IDLE) || write_reg;
  assign discard        = (state_reg == DISCARD);
  assign read_c         = ext_read | discard;
  assign pop            = read_c && (entries_reg != '0);
  assign ext_pop        = ext_read && (entries_reg != '0);
  assign room           = FULL - entries_reg;
  assign set_size       = fifo_temp ? CNT_WIDTH'(4) : CNT_WIDTH'(3);
  assign last_word      = (idx_reg == (temp_en_reg ? 2'd3 : 2'd2));
  assign mode_off_enter = (fifo_mode == MODE_OFF) && (prev_mode_reg != MODE_OFF);

  // Occupancy seen by the next word when it lands, one cycle after being registered.
  assign base_next    = entries_reg + (write_reg ? ONE : '0) - (ext_pop ? ONE : '0);
  assign need_discard = stream_set_reg && (base_next == FULL) && !ext_read;

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    write_next      = 1'b0;
    data_next       = data_reg;
    flush_next      = 1'b0;
    overrun_next    = overrun_reg & ~clear_status;
    trig_next       = trig_reg;
    post_next       = post_reg;
    stream_set_next = stream_set_reg;
    temp_en_next    = temp_en_reg;
    capture         = 1'b0;
    emit            = 1'b0;

    entries_next = entries_reg;
    if (write_reg && !pop) begin
      if (entries_reg != FULL) entries_next = entries_reg + ONE;
    end else if (!write_reg && pop) begin
      entries_next = entries_reg - ONE;
    end

    if (write_reg && trig_reg && (post_reg != '1)) post_next = post_reg + ONE;
    if (trigger && (fifo_mode == MODE_TRIG) && !trig_reg) begin
      trig_next = 1'b1;
      post_next = '0;
    end

    // Sets are accepted whole or not at all; triggered-mode drops are silent.
    if (sample_valid && (fifo_mode != MODE_OFF)) begin
      if (busy_c)
        overrun_next = 1'b1;
      else if ((fifo_mode == MODE_OLDEST) && (room < set_size))
        overrun_next = 1'b1;
      else if (!((fifo_mode == MODE_TRIG) && trig_reg && (post_reg >= samples_ext)))
        capture = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (capture) begin
          state_next      = WRITE;
          idx_next        = 2'd0;
          stream_set_next = fifo_mode[1];
          temp_en_next    = fifo_temp;
        end
      end
      WRITE: begin
        if (need_discard) state_next = DISCARD;
        else              emit       = 1'b1;
      end
      DISCARD: emit = 1'b1;
      default: state_next = IDLE;
    endcase

    if (emit) begin
      write_next = 1'b1;
      data_next  = WIDTH'(word[idx_reg]);
      if (last_word) begin
        state_next = IDLE;
      end else begin
        idx_next   = idx_reg + 2'd1;
        state_next = WRITE;
      end
    end

    if (mode_off_enter) begin
      state_next   = IDLE;
      idx_next     = 2'd0;
      write_next   = 1'b0;
      flush_next   = 1'b1;
      entries_next = '0;
      trig_next    = 1'b0;
      post_next    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      idx_reg        <= 2'd0;
      write_reg      <= 1'b0;
      data_reg       <= '0;
      flush_reg      <= 1'b0;
      entries_reg    <= '0;
      overrun_reg    <= 1'b0;
      trig_reg       <= 1'b0;
      post_reg       <= '0;
      stream_set_reg <= 1'b0;
      temp_en_reg    <= 1'b0;
      prev_mode_reg  <= MODE_OFF;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      write_reg      <= write_next;
      data_reg       <= data_next;
      flush_reg      <= flush_next;
      entries_reg    <= entries_next;
      overrun_reg    <= overrun_next;
      trig_reg       <= trig_next;
      post_reg       <= post_next;
      stream_set_reg <= stream_set_next;
      temp_en_reg    <= temp_en_next;
      prev_mode_reg  <= fifo_mode;
    end
  end

  // Payload holding register needs no reset; it is only read after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      sample_reg[0] <= x_data;
      sample_reg[1] <= y_data;
      sample_reg[2] <= z_data;
      sample_reg[3] <= temp_data;
    end
  end

  assign fifo_write      = write_reg;
  assign fifo_data_write = data_reg;
  assign fifo_flush      = flush_reg;
  assign fifo_read       = rst & read_c;
  assign entries         = entries_reg;
  assign watermark       = (fifo_samples != 10'd0) && (entries_reg >= samples_ext);
  assign overrun         = overrun_reg;
  assign busy            = busy_c;

endmodule
